// File: rtl/execute_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_muldiv: iterative RV64M multiply/divide (shift-add / restoring)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module execute_muldiv #(
  parameter int XLEN      = 64,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] regE_i_valA,
  input  logic [XLEN-1:0] regE_i_valB,
  input  logic [3:0]      regE_i_mdu_op,
  input  logic            regE_i_mdu_valid,
  input  logic            ctrl_i_flush,
  output logic [XLEN-1:0] mdu_o_result,
  output logic            mdu_o_done,
  output logic            mdu_o_stall
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32X = 64'hFFFF_FFFF_8000_0000;

  state_t       state, state_nx;
  logic [6:0]   count, count_nx;
  logic [127:0] acc, acc_nx, acc_step, prod_s;
  logic [63:0]  opb, opb_nx, result_nx;
  logic [3:0]   op_q, op_nx;
  logic         neg_q, neg_nx, done_nx;

  // Decode of the incoming op
  logic in_mul, in_w, in_asgn, in_bsgn, in_rem, in_rsvd;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, fast_val;
  logic a_neg, b_neg, div0, ovf, mzero, fast;

  always_comb begin
    in_mul  = (regE_i_mdu_op <= 4'd3) || (regE_i_mdu_op == 4'd8);
    in_w    = (regE_i_mdu_op >= 4'd8);
    in_asgn = regE_i_mdu_op inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
    in_bsgn = regE_i_mdu_op inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
    in_rem  = regE_i_mdu_op inside {4'd6, 4'd7, 4'd11, 4'd12};
    in_rsvd = (regE_i_mdu_op >= 4'd13);
    a_ext = in_w ? {{32{in_asgn & regE_i_valA[31]}}, regE_i_valA[31:0]} : regE_i_valA;
    b_ext = in_w ? {{32{in_bsgn & regE_i_valB[31]}}, regE_i_valB[31:0]} : regE_i_valB;
    a_neg = in_asgn & a_ext[63];
    b_neg = in_bsgn & b_ext[63];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    div0  = ~in_mul & ~in_rsvd & (b_ext == 64'd0);
    ovf   = ~in_mul & in_asgn & in_bsgn & (a_ext == (in_w ? MIN32X : MIN64)) & (b_ext == '1);
    mzero = EARLY_OUT & in_mul & ((a_ext == 64'd0) | (b_ext == 64'd0));
    fast  = in_rsvd | div0 | ovf | mzero;
    fast_val = 64'd0;
    if (div0)
      fast_val = in_rem ? (in_w ? {{32{regE_i_valA[31]}}, regE_i_valA[31:0]} : regE_i_valA) : '1;
    else if (ovf)
      fast_val = in_rem ? 64'd0 : a_ext;
  end

  // Decode of the latched op
  logic q_mul, q_w, q_high, q_rem;
  always_comb begin
    q_mul  = (op_q <= 4'd3) || (op_q == 4'd8);
    q_w    = (op_q >= 4'd8);
    q_high = op_q inside {4'd1, 4'd2, 4'd3};
    q_rem  = op_q inside {4'd6, 4'd7, 4'd11, 4'd12};
  end

  // One radix-2 step; acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [64:0] add_sum, sub_rem, sub_diff;
  logic [63:0] dv, dv_s, fin;
  always_comb begin
    add_sum  = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opb} : 65'd0);
    sub_rem  = acc[127:63];
    sub_diff = sub_rem - {1'b0, opb};
    if (q_mul)
      acc_step = {add_sum, acc[63:1]};
    else if (!sub_diff[64])
      acc_step = {sub_diff[63:0], acc[62:0], 1'b1};
    else
      acc_step = {acc[126:0], 1'b0};

    prod_s = neg_q ? -acc_step : acc_step;
    dv     = q_rem ? acc_step[127:64] : (q_w ? {32'd0, acc_step[31:0]} : acc_step[63:0]);
    dv_s   = neg_q ? -dv : dv;
    if (q_mul)
      fin = q_w ? {{32{acc_step[63]}}, acc_step[63:32]}
                : (q_high ? prod_s[127:64] : prod_s[63:0]);
    else
      fin = q_w ? {{32{dv_s[31]}}, dv_s[31:0]} : dv_s;
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    acc_nx    = acc;
    opb_nx    = opb;
    op_nx     = op_q;
    neg_nx    = neg_q;
    result_nx = mdu_o_result;
    done_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (regE_i_mdu_valid && !ctrl_i_flush) begin
          op_nx  = regE_i_mdu_op;
          neg_nx = in_mul ? (a_neg ^ b_neg) : (in_rem ? a_neg : (a_neg ^ b_neg));
          opb_nx = b_mag;
          // W divides start with the dividend in the upper half so 32 steps suffice
          acc_nx = (in_w && !in_mul) ? {64'd0, a_mag[31:0], 32'd0} : {64'd0, a_mag};
          if (fast) begin
            count_nx  = 7'd0;
            result_nx = fast_val;
            done_nx   = 1'b1;
            state_nx  = S_DONE;
          end else begin
            count_nx = in_w ? 7'd32 : 7'd64;
            state_nx = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_nx   = acc_step;
        count_nx = count - 7'd1;
        if (count == 7'd1) begin
          result_nx = fin;
          done_nx   = 1'b1;
          state_nx  = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (ctrl_i_flush) begin
      state_nx  = S_IDLE;
      done_nx   = 1'b0;
      result_nx = mdu_o_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      count        <= 7'd0;
      acc          <= 128'd0;
      opb          <= 64'd0;
      op_q         <= 4'd0;
      neg_q        <= 1'b0;
      mdu_o_result <= 64'd0;
      mdu_o_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      acc          <= acc_nx;
      opb          <= opb_nx;
      op_q         <= op_nx;
      neg_q        <= neg_nx;
      mdu_o_result <= result_nx;
      mdu_o_done   <= done_nx;
    end
  end

  assign mdu_o_stall = regE_i_mdu_valid & ~ctrl_i_flush & (state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_execute_muldiv: directed + random checks against an arithmetic model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] regE_i_valA = '0, regE_i_valB = '0;
  logic [3:0]  regE_i_mdu_op = '0;
  logic        regE_i_mdu_valid = 1'b0, ctrl_i_flush = 1'b0;
  logic [63:0] mdu_o_result;
  logic        mdu_o_done, mdu_o_stall;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_result;

  execute_muldiv dut (
    .clk(clk), .rst(rst),
    .regE_i_valA(regE_i_valA), .regE_i_valB(regE_i_valB),
    .regE_i_mdu_op(regE_i_mdu_op), .regE_i_mdu_valid(regE_i_mdu_valid),
    .ctrl_i_flush(ctrl_i_flush),
    .mdu_o_result(mdu_o_result), .mdu_o_done(mdu_o_done), .mdu_o_stall(mdu_o_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural result, straight from the RV64M definitions
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ax, bx, p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, m32;
    a32 = a[31:0]; b32 = b[31:0]; sa = a; sb = b; sa32 = a32; sb32 = b32;
    case (op)
      4'd0: return a * b;
      4'd1: begin ax = {{64{a[63]}}, a}; bx = {{64{b[63]}}, b}; p = ax * bx; return p[127:64]; end
      4'd2: begin ax = {{64{a[63]}}, a}; bx = {64'd0, b}; p = ax * bx; return p[127:64]; end
      4'd3: begin ax = {64'd0, a}; bx = {64'd0, b}; p = ax * bx; return p[127:64]; end
      4'd4: if (b == 0) return '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) return a; else return sa / sb;
      4'd5: if (b == 0) return '1; else return a / b;
      4'd6: if (b == 0) return a; else if (a == 64'h8000_0000_0000_0000 && b == '1) return 0; else return sa % sb;
      4'd7: if (b == 0) return a; else return a % b;
      4'd8: begin m32 = a32 * b32; return sx32(m32); end
      4'd9: if (b32 == 0) return '1; else if (a32 == 32'h8000_0000 && b32 == '1) return sx32(a32); else return sx32(sa32 / sb32);
      4'd10: if (b32 == 0) return '1; else return sx32(a32 / b32);
      4'd11: if (b32 == 0) return sx32(a32); else if (a32 == 32'h8000_0000 && b32 == '1) return 0; else return sx32(sa32 % sb32);
      4'd12: if (b32 == 0) return sx32(a32); else return sx32(a32 % b32);
      default: return 0;
    endcase
  endfunction

  // Iteration count N: 0 for the shortcut cases, otherwise the operand width
  function automatic int n_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit is_mul, w;
    is_mul = (op <= 3) || (op == 8);
    w = (op >= 8);
    if (op >= 13) return 0;
    if (is_mul) begin
      if (w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0)) return 0;
    end else begin
      if (w ? (b[31:0] == 0) : (b == 0)) return 0;
      if ((op == 4 || op == 6) && a == 64'h8000_0000_0000_0000 && b == '1) return 0;
      if ((op == 9 || op == 11) && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 0;
    end
    return w ? 32 : 64;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op in the next cycle (cycle T) and follows it to its done pulse
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int n, done_k, stall_bad;
    logic [63:0] exp_r;
    @(posedge clk); #1;
    check("done_single_pulse", {63'd0, mdu_o_done}, 64'd0);
    regE_i_mdu_op = op; regE_i_valA = a; regE_i_valB = b; regE_i_mdu_valid = 1'b1;
    exp_r = model(op, a, b);
    n = n_of(op, a, b);
    #1;
    check("stall_at_accept", {63'd0, mdu_o_stall}, 64'd1);
    done_k = 0; stall_bad = 0;
    for (int k = 1; k <= 80 && done_k == 0; k++) begin
      @(posedge clk); #1;
      if (mdu_o_done) begin
        done_k = k;
        check("latency", 64'(k), 64'(n + 1));
        check("result", mdu_o_result, exp_r);
        check("stall_in_done", {63'd0, mdu_o_stall}, 64'd0);
        last_result = mdu_o_result;
      end else if (mdu_o_stall !== 1'b1) begin
        stall_bad++;
      end
    end
    regE_i_mdu_valid = 1'b0;
    check("done_seen", 64'(done_k != 0), 64'd1);
    check("stall_while_busy", 64'(stall_bad), 64'd0);
  endtask

  task automatic expect_quiet(input string tag, input logic [63:0] hold);
    int seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (mdu_o_done) seen++;
    end
    check({tag, "_no_done"}, 64'(seen), 64'd0);
    check({tag, "_result_held"}, mdu_o_result, hold);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom(), 32'h8000_0000};
      4: return 64'($urandom_range(0, 15));
      5: return {32'hFFFF_FFFF, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [63:0] held;
    logic [3:0]  rop;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {63'd0, mdu_o_done}, 64'd0);
    check("reset_result", mdu_o_result, 64'd0);
    check("reset_stall", {63'd0, mdu_o_stall}, 64'd0);
    @(negedge clk) rst = 1'b1;

    run_op(4'd0, 64'd7, -64'sd3);
    check("mul_7_m3", last_result, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(4'd3, '1, '1);
    check("mulhu_ones", last_result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(4'd1, '1, '1);
    check("mulh_ones", last_result, 64'd0);
    run_op(4'd4, -64'sd7, 64'd2);
    check("div_m7_2", last_result, -64'sd3);
    run_op(4'd6, -64'sd7, 64'd2);
    check("rem_m7_2", last_result, '1);
    run_op(4'd5, 64'd7, 64'd0);
    check("divu_by0", last_result, '1);
    run_op(4'd6, 64'd5, 64'd0);
    check("rem_by0", last_result, 64'd5);
    run_op(4'd4, 64'h8000_0000_0000_0000, '1);
    check("div_ovf", last_result, 64'h8000_0000_0000_0000);
    run_op(4'd11, 64'h8000_0000, '1);
    check("remw_ovf", last_result, 64'd0);
    run_op(4'd10, 64'hFFFF_FFFF, 64'd1);
    check("divuw_ones", last_result, '1);
    run_op(4'd12, 64'h1_8000_0007, 64'h2);
    run_op(4'd2, -64'sd5, 64'd3);

    // Flush in the middle of a divide
    held = mdu_o_result;
    @(posedge clk); #1;
    regE_i_mdu_op = 4'd4; regE_i_valA = 64'h1234_5678_9ABC_DEF0; regE_i_valB = 64'd3;
    regE_i_mdu_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ctrl_i_flush = 1'b1; regE_i_mdu_valid = 1'b0;
    @(posedge clk); #1;
    ctrl_i_flush = 1'b0;
    expect_quiet("flush_calc", held);
    run_op(4'd5, 64'd100, 64'd7);

    // Flush while idle with a valid op present
    held = mdu_o_result;
    @(posedge clk); #1;
    regE_i_mdu_op = 4'd5; regE_i_valA = 64'd1000; regE_i_valB = 64'd9;
    regE_i_mdu_valid = 1'b1; ctrl_i_flush = 1'b1;
    #1;
    check("flush_idle_stall", {63'd0, mdu_o_stall}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    regE_i_mdu_valid = 1'b0; ctrl_i_flush = 1'b0;
    expect_quiet("flush_idle", held);

    // Asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    regE_i_mdu_op = 4'd0; regE_i_valA = 64'hDEAD_BEEF; regE_i_valB = 64'h1234;
    regE_i_mdu_valid = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_done", {63'd0, mdu_o_done}, 64'd0);
    check("async_rst_result", mdu_o_result, 64'd0);
    regE_i_mdu_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    run_op(4'd8, 64'h10000, 64'h10000);
    check("mulw_wrap", last_result, 64'd0);

    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op(rop, rnd_operand(), rnd_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
